// File: rtl/b_type_decoder_pkg.sv
// Shared constants and helpers for the RV32I B-type decoder.
package b_type_decoder_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'd0,
        BR_BNE  = 3'd1,
        BR_BLT  = 3'd4,
        BR_BGE  = 3'd5,
        BR_BLTU = 3'd6,
        BR_BGEU = 3'd7
    } br_op_e;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

endpackage

// File: rtl/b_type_decoder_fields.sv
// Combinational B-type field and immediate extractor.
module b_type_decoder_fields #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instruction,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [2:0]      funct3,
    output logic [12:0]     imm,
    output logic [XLEN-1:0] imm_sext
);

    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct3 = instruction[14:12];

    assign imm = {instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};

    assign imm_sext = {{(XLEN-13){imm[12]}}, imm};

endmodule

// File: rtl/b_type_decoder.sv
// Registered RV32I conditional-branch decoder: fields, class, target.
module b_type_decoder
    import b_type_decoder_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [2:0]      funct3,
    output logic [12:0]     imm,
    output logic [XLEN-1:0] imm_sext,
    output logic            is_branch,
    output logic            illegal,
    output logic [2:0]      br_op,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    logic [4:0]      f_rs1;
    logic [4:0]      f_rs2;
    logic [2:0]      f_funct3;
    logic [12:0]     f_imm;
    logic [XLEN-1:0] f_imm_sext;

    b_type_decoder_fields #(.XLEN(XLEN)) u_fields (
        .instruction (instruction),
        .rs1         (f_rs1),
        .rs2         (f_rs2),
        .funct3      (f_funct3),
        .imm         (f_imm),
        .imm_sext    (f_imm_sext)
    );

    logic            c_is_branch;
    logic            c_illegal;
    logic [2:0]      c_br_op;
    logic [XLEN-1:0] c_target;
    logic            c_misaligned;

    always_comb begin
        c_is_branch  = (instruction[6:0] == OPC_BRANCH);
        c_illegal    = c_is_branch && !f3_legal(f_funct3);
        c_br_op      = (c_is_branch && !c_illegal) ? f_funct3 : 3'd0;
        c_target     = pc + f_imm_sext;
        c_misaligned = c_is_branch && !c_illegal && (c_target[1:0] != 2'b00);
    end

    logic            out_valid_q, out_valid_d;
    logic [4:0]      rs1_q, rs1_d;
    logic [4:0]      rs2_q, rs2_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [12:0]     imm_q, imm_d;
    logic [XLEN-1:0] imm_sext_q, imm_sext_d;
    logic            is_branch_q, is_branch_d;
    logic            illegal_q, illegal_d;
    logic [2:0]      br_op_q, br_op_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            misaligned_q, misaligned_d;

    // Data outputs hold while idle; only out_valid tracks in_valid.
    always_comb begin
        out_valid_d  = in_valid;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        funct3_d     = funct3_q;
        imm_d        = imm_q;
        imm_sext_d   = imm_sext_q;
        is_branch_d  = is_branch_q;
        illegal_d    = illegal_q;
        br_op_d      = br_op_q;
        target_d     = target_q;
        misaligned_d = misaligned_q;
        if (in_valid) begin
            rs1_d        = f_rs1;
            rs2_d        = f_rs2;
            funct3_d     = f_funct3;
            imm_d        = f_imm;
            imm_sext_d   = f_imm_sext;
            is_branch_d  = c_is_branch;
            illegal_d    = c_illegal;
            br_op_d      = c_br_op;
            target_d     = c_target;
            misaligned_d = c_misaligned;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            funct3_q     <= '0;
            imm_q        <= '0;
            imm_sext_q   <= '0;
            is_branch_q  <= 1'b0;
            illegal_q    <= 1'b0;
            br_op_q      <= '0;
            target_q     <= '0;
            misaligned_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            funct3_q     <= funct3_d;
            imm_q        <= imm_d;
            imm_sext_q   <= imm_sext_d;
            is_branch_q  <= is_branch_d;
            illegal_q    <= illegal_d;
            br_op_q      <= br_op_d;
            target_q     <= target_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign rs1        = rs1_q;
    assign rs2        = rs2_q;
    assign funct3     = funct3_q;
    assign imm        = imm_q;
    assign imm_sext   = imm_sext_q;
    assign is_branch  = is_branch_q;
    assign illegal    = illegal_q;
    assign br_op      = br_op_q;
    assign target     = target_q;
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_b_type_decoder.sv
// Scoreboard bench for b_type_decoder.
module tb_b_type_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        out_valid;
    logic [4:0]  rs1, rs2;
    logic [2:0]  funct3;
    logic [12:0] imm;
    logic [31:0] imm_sext;
    logic        is_branch, illegal;
    logic [2:0]  br_op;
    logic [31:0] target;
    logic        misaligned;

    always #5 clk = ~clk;

    b_type_decoder #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .instruction (instruction),
        .pc          (pc),
        .out_valid   (out_valid),
        .rs1         (rs1),
        .rs2         (rs2),
        .funct3      (funct3),
        .imm         (imm),
        .imm_sext    (imm_sext),
        .is_branch   (is_branch),
        .illegal     (illegal),
        .br_op       (br_op),
        .target      (target),
        .misaligned  (misaligned)
    );

    typedef struct {
        logic        ov;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [12:0] imm;
        logic [31:0] sext;
        logic        isb;
        logic        ill;
        logic [2:0]  op;
        logic [31:0] tgt;
        logic        mis;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [31:0] ins,
                                  input logic [31:0] p);
        int signed off;
        m.rs1  = ins[19:15];
        m.rs2  = ins[24:20];
        m.f3   = ins[14:12];
        off    = 0;
        off   += ins[11:8] * 2;
        off   += ins[30:25] * 32;
        off   += ins[7] * 2048;
        off   -= ins[31] * 4096;
        m.imm  = off[12:0];
        m.sext = off;
        m.tgt  = p + off;
        m.isb  = (ins[6:0] == 7'h63);
        m.ill  = m.isb && (m.f3 == 3'd2 || m.f3 == 3'd3);
        m.op   = (m.isb && !m.ill) ? m.f3 : 3'd0;
        m.mis  = m.isb && !m.ill && (m.tgt[1:0] != 2'b00);
    endfunction

    task automatic step(input logic r, input logic v,
                        input logic [31:0] ins, input logic [31:0] p);
        exp_t e;
        @(negedge clk);
        rst = r;
        in_valid = v;
        instruction = ins;
        pc = p;
        if (r) begin
            m = '{default: '0};
        end else begin
            m.ov = v;
            if (v) model(ins, p);
        end
        q.push_back(m);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = q.pop_front();
            check("out_valid", 32'(out_valid), 32'(e.ov));
            check("rs1", 32'(rs1), 32'(e.rs1));
            check("rs2", 32'(rs2), 32'(e.rs2));
            check("funct3", 32'(funct3), 32'(e.f3));
            check("imm", 32'(imm), 32'(e.imm));
            check("imm_sext", imm_sext, e.sext);
            check("is_branch", 32'(is_branch), 32'(e.isb));
            check("illegal", 32'(illegal), 32'(e.ill));
            check("br_op", 32'(br_op), 32'(e.op));
            check("target", target, e.tgt);
            check("misaligned", 32'(misaligned), 32'(e.mis));
        end
    endtask

    initial begin
        logic [31:0] ins;
        rst = 1'b1;
        in_valid = 1'b0;
        instruction = '0;
        pc = '0;
        m = '{default: '0};

        step(1'b1, 1'b0, 32'h0, 32'h0);
        check("rst_ov", 32'(out_valid), 32'd0);
        check("rst_tgt", target, 32'd0);

        step(1'b0, 1'b1, 32'h002083C7, 32'h0);
        check("nb_imm", 32'(imm), 32'h806);
        check("nb_isb", 32'(is_branch), 32'd0);
        check("nb_rs2", 32'(rs2), 32'd2);

        step(1'b0, 1'b1, 32'h00208463, 32'h100);
        check("beq_tgt", target, 32'h108);
        check("beq_sext", imm_sext, 32'h8);
        check("beq_isb", 32'(is_branch), 32'd1);

        step(1'b0, 1'b1, 32'hFE419EE3, 32'h200);
        check("bne_imm", 32'(imm), 32'h1FFC);
        check("bne_sext", imm_sext, 32'hFFFFFFFC);
        check("bne_tgt", target, 32'h1FC);
        check("bne_op", 32'(br_op), 32'd1);

        step(1'b0, 1'b1, 32'h0020A463, 32'h100);
        check("ill_ill", 32'(illegal), 32'd1);
        check("ill_op", 32'(br_op), 32'd0);
        check("ill_mis", 32'(misaligned), 32'd0);

        step(1'b0, 1'b1, 32'h00208463, 32'h102);
        check("mis_tgt", target, 32'h10A);
        check("mis_mis", 32'(misaligned), 32'd1);

        step(1'b0, 1'b1, 32'h00208463, 32'hFFFFFFFC);
        check("wrap_tgt", target, 32'h4);

        // Extreme offsets: -4096 and +4094.
        step(1'b0, 1'b1, 32'h80000063, 32'h2000);
        check("min_sext", imm_sext, 32'hFFFFF000);
        step(1'b0, 1'b1, 32'h7E000FE3, 32'h0);
        check("max_imm", 32'(imm), 32'hFFE);

        step(1'b0, 1'b0, 32'hFFFFFFFF, 32'h12345678);
        check("hold_ov", 32'(out_valid), 32'd0);
        check("hold_imm", 32'(imm), 32'hFFE);

        step(1'b0, 1'b1, 32'h00208463, 32'h100);
        step(1'b1, 1'b1, 32'hFE419EE3, 32'h200);
        check("rstv_ov", 32'(out_valid), 32'd0);
        check("rstv_rs1", 32'(rs1), 32'd0);

        step(1'b0, 1'b1, 32'hFE419EE3, 32'h200);
        check("first_ov", 32'(out_valid), 32'd1);

        for (int i = 0; i < 60; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 2) != 0) ins[6:0] = 7'b1100011;
            step(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0),
                 ins, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
